// File: rtl/ram_arbiter_if.sv
// Bus bundle between the three RAM requesters, the arbiter and the RAM macro.
// master = requester/RAM side, slave = arbiter side.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 4
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_instr_boundary;
    logic                  cpu_halt;

    logic                  vid_req;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic                  vid_ack;
    logic [DATA_WIDTH-1:0] vid_rdata;
    logic                  vid_rvalid;

    logic                  ss_lock_req;
    logic                  ss_locked;
    logic                  ss_req;
    logic                  ss_we;
    logic [ADDR_WIDTH-1:0] ss_addr;
    logic [DATA_WIDTH-1:0] ss_wdata;
    logic                  ss_ack;
    logic [DATA_WIDTH-1:0] ss_rdata;
    logic                  ss_rvalid;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_instr_boundary,
        output vid_req, vid_addr,
        output ss_lock_req, ss_req, ss_we, ss_addr, ss_wdata,
        output ram_rdata,
        input  cpu_rdata, cpu_halt,
        input  vid_ack, vid_rdata, vid_rvalid,
        input  ss_locked, ss_ack, ss_rdata, ss_rvalid,
        input  ram_addr, ram_we, ram_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_instr_boundary,
        input  vid_req, vid_addr,
        input  ss_lock_req, ss_req, ss_we, ss_addr, ss_wdata,
        input  ram_rdata,
        output cpu_rdata, cpu_halt,
        output vid_ack, vid_rdata, vid_rvalid,
        output ss_locked, ss_ack, ss_rdata, ss_rvalid,
        output ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port CPU data RAM arbiter: CPU zero-wait in SHARED, video in idle slots,
// savestate exclusive once the CPU is halted at an instruction boundary.
module ram_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic         clk,
    input logic         reset_n,
    ram_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {SHARED, LOCK_WAIT, LOCKED, UNLOCK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_SS} owner_t;

    state_t                state, state_nxt;
    owner_t                owner, owner_nxt;
    logic [CW-1:0]         starve_cnt, starve_nxt;
    logic                  halt;
    logic                  gnt_cpu, gnt_vid, gnt_ss;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  we;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= SHARED;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            halt       <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_nxt;
            halt       <= (state_nxt == LOCKED) || (state_nxt == UNLOCK);
        end
    end

    always_comb begin
        state_nxt  = state;
        starve_nxt = '0;
        gnt_cpu    = 1'b0;
        gnt_vid    = 1'b0;
        gnt_ss     = 1'b0;
        case (state)
            SHARED, LOCK_WAIT: begin
                if (bus.cpu_req)      gnt_cpu = 1'b1;
                else if (bus.vid_req) gnt_vid = 1'b1;
                // A boundary coinciding with the lock request is not consumed.
                if (state == SHARED) begin
                    if (bus.ss_lock_req) state_nxt = LOCK_WAIT;
                end else if (!bus.ss_lock_req) begin
                    state_nxt = SHARED;
                end else if (bus.cpu_instr_boundary) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (bus.vid_req && (starve_cnt == CW'(STARVE_LIMIT) || !bus.ss_req))
                    gnt_vid = 1'b1;
                else if (bus.ss_req)
                    gnt_ss = 1'b1;
                starve_nxt = starve_cnt;
                if (gnt_vid)
                    starve_nxt = '0;
                else if (bus.vid_req && starve_cnt != CW'(STARVE_LIMIT))
                    starve_nxt = starve_cnt + CW'(1);
                if (!bus.ss_lock_req) begin
                    state_nxt  = UNLOCK;
                    starve_nxt = '0;
                end
            end
            UNLOCK: begin
                gnt_vid   = bus.vid_req;
                state_nxt = SHARED;
            end
            default: state_nxt = SHARED;
        endcase
        // Nothing reaches the RAM while reset is held.
        if (!reset_n) begin
            gnt_cpu = 1'b0;
            gnt_vid = 1'b0;
            gnt_ss  = 1'b0;
        end
    end

    always_comb begin
        addr      = '0;
        wdata     = '0;
        we        = 1'b0;
        owner_nxt = OWN_NONE;
        if (gnt_cpu) begin
            addr  = bus.cpu_addr;
            wdata = bus.cpu_wdata;
            we    = bus.cpu_we;
            if (!bus.cpu_we) owner_nxt = OWN_CPU;
        end else if (gnt_vid) begin
            addr      = bus.vid_addr;
            owner_nxt = OWN_VID;
        end else if (gnt_ss) begin
            addr  = bus.ss_addr;
            wdata = bus.ss_wdata;
            we    = bus.ss_we;
            if (!bus.ss_we) owner_nxt = OWN_SS;
        end
    end

    assign bus.ram_addr   = addr;
    assign bus.ram_wdata  = wdata;
    assign bus.ram_we     = we;
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.vid_rdata  = bus.ram_rdata;
    assign bus.ss_rdata   = bus.ram_rdata;
    assign bus.vid_ack    = gnt_vid;
    assign bus.ss_ack     = gnt_ss;
    assign bus.vid_rvalid = (owner == OWN_VID);
    assign bus.ss_rvalid  = (owner == OWN_SS);
    assign bus.cpu_halt   = halt;
    assign bus.ss_locked  = (state == LOCKED);
endmodule

// File: tb/tb_ram_arbiter.sv
// Random and directed stimulus for ram_arbiter, checked against a behavioural
// model of the sharing rules plus a shadow copy of the RAM contents.
module tb_ram_arbiter;
    localparam int AW = 12, DW = 4, LIM = 8;
    localparam int M_SH = 0, M_LW = 1, M_LK = 2, M_UL = 3;
    localparam int G_NONE = 0, G_CPU = 1, G_VID = 2, G_SS = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // RAM macro: 1-cycle synchronous read
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= ram[bus.ram_addr];
    end

    int n_chk = 0, n_err = 0;
    int mode = M_SH, starve = 0;
    bit p_cpu, p_vid, p_ss;
    logic [DW-1:0] p_data;
    int last_g;
    bit seen_lock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cpu_instr_boundary = 0;
        bus.vid_req = 0; bus.vid_addr = '0;
        bus.ss_lock_req = 0; bus.ss_req = 0; bus.ss_we = 0; bus.ss_addr = '0; bus.ss_wdata = '0;
    endtask

    // One clock: inputs already driven just after negedge; check, then advance the model.
    task automatic cyc();
        int g;
        logic we_e;
        logic [AW-1:0] a_e;
        logic [DW-1:0] d_e;
        #3;
        g = G_NONE;
        if (reset_n) begin
            if (mode == M_SH || mode == M_LW) begin
                if (bus.cpu_req) g = G_CPU; else if (bus.vid_req) g = G_VID;
            end else if (mode == M_LK) begin
                if (bus.vid_req && (starve >= LIM || !bus.ss_req)) g = G_VID;
                else if (bus.ss_req) g = G_SS;
            end else if (bus.vid_req) g = G_VID;
        end
        we_e = (g == G_CPU) ? bus.cpu_we : (g == G_SS) ? bus.ss_we : 1'b0;
        a_e  = (g == G_CPU) ? bus.cpu_addr : (g == G_VID) ? bus.vid_addr :
               (g == G_SS) ? bus.ss_addr : '0;
        d_e  = (g == G_CPU) ? bus.cpu_wdata : (g == G_SS) ? bus.ss_wdata : '0;
        last_g = g;
        seen_lock |= bus.cpu_halt | bus.ss_locked;

        chk("vid_ack", bus.vid_ack, g == G_VID);
        chk("ss_ack", bus.ss_ack, g == G_SS);
        chk("cpu_halt", bus.cpu_halt, mode == M_LK || mode == M_UL);
        chk("ss_locked", bus.ss_locked, mode == M_LK);
        chk("vid_rvalid", bus.vid_rvalid, p_vid);
        chk("ss_rvalid", bus.ss_rvalid, p_ss);
        chk("ram_we", bus.ram_we, we_e);
        chk("ram_addr", bus.ram_addr, a_e);
        chk("ram_wdata", bus.ram_wdata, d_e);
        if (p_vid) chk("vid_rdata", bus.vid_rdata, p_data);
        if (p_ss)  chk("ss_rdata", bus.ss_rdata, p_data);
        if (p_cpu) chk("cpu_rdata", bus.cpu_rdata, p_data);

        @(posedge clk);
        if (!reset_n) begin
            mode = M_SH; starve = 0; p_cpu = 0; p_vid = 0; p_ss = 0;
        end else begin
            p_cpu  = (g == G_CPU) && !we_e;
            p_vid  = (g == G_VID);
            p_ss   = (g == G_SS) && !we_e;
            p_data = mdl_mem[a_e];
            if (we_e) mdl_mem[a_e] = d_e;
            if (mode == M_LK) begin
                if (g == G_VID) starve = 0;
                else if (bus.vid_req && starve < LIM) starve++;
            end
            case (mode)
                M_SH: if (bus.ss_lock_req) mode = M_LW;
                M_LW: if (!bus.ss_lock_req) mode = M_SH;
                      else if (bus.cpu_instr_boundary) mode = M_LK;
                M_LK: if (!bus.ss_lock_req) begin mode = M_UL; starve = 0; end
                default: mode = M_SH;
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        int nv;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = DW'(i ^ (i >> 4));
            mdl_mem[i] = DW'(i ^ (i >> 4));
        end
        ram[12'h0A5] = 4'h7; mdl_mem[12'h0A5] = 4'h7;
        idle();
        reset_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc();                       // still in reset: reset values
        reset_n = 1;

        // SHARED: CPU every other cycle, video held; CPU read of 0x0A5
        for (int i = 0; i < 10; i++) begin
            bus.vid_req = 1; bus.vid_addr = AW'(i);
            bus.cpu_req = (i % 2 == 0); bus.cpu_we = 0; bus.cpu_addr = 12'h0A5;
            cyc();
            if (i == 0) chk("cpu_rd_a5", bus.cpu_rdata, 4'h7);
        end
        idle(); cyc();

        // Lock with boundary 5 cycles later; CPU keeps trying to write
        for (int i = 0; i < 7; i++) begin
            bus.ss_lock_req = 1; bus.cpu_instr_boundary = (i == 5);
            bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = AW'(12'h200 + i); bus.cpu_wdata = 4'hF;
            cyc();
            if (i == 5) begin
                chk("lock_halt", bus.cpu_halt, 1);
                chk("lock_locked", bus.ss_locked, 1);
            end
        end

        // Starvation pattern: 8 ss, 1 video
        nv = 0;
        for (int i = 0; i < 27; i++) begin
            bus.ss_req = 1; bus.ss_we = 0; bus.ss_addr = AW'(i);
            bus.vid_req = 1; bus.vid_addr = AW'(12'h300 + i);
            cyc();
            if (last_g == G_VID) nv++;
            if (i == 8) chk("starve_slot9", last_g, G_VID);
        end
        chk("starve_vid_acks", nv, 3);

        // ss write then read 0x123, then unlock
        bus.vid_req = 0; bus.cpu_req = 0; bus.cpu_we = 0;
        bus.ss_req = 1; bus.ss_we = 1; bus.ss_addr = 12'h123; bus.ss_wdata = 4'hC;
        cyc();
        bus.ss_we = 0;
        cyc();
        chk("ss_rd_123", bus.ss_rdata, 4'hC);
        bus.ss_req = 0; bus.ss_lock_req = 0;
        cyc();
        chk("unlock_locked", bus.ss_locked, 0);
        chk("unlock_halt", bus.cpu_halt, 1);
        cyc();
        chk("shared_halt", bus.cpu_halt, 0);

        // Lock pulse without boundary
        seen_lock = 0;
        bus.ss_lock_req = 1; cyc(); cyc();
        bus.ss_lock_req = 0; cyc(); cyc(); cyc();
        chk("pulse_no_lock", seen_lock, 0);

        // Reset while locked with an ss read in flight
        bus.ss_lock_req = 1; cyc();
        bus.cpu_instr_boundary = 1; cyc();
        bus.cpu_instr_boundary = 0;
        bus.ss_req = 1; bus.ss_we = 0; bus.ss_addr = 12'h0A5; cyc();
        reset_n = 0; bus.ss_req = 0; cyc();
        reset_n = 1; idle();
        chk("rst_halt", bus.cpu_halt, 0);
        chk("rst_locked", bus.ss_locked, 0);
        chk("rst_ss_rvalid", bus.ss_rvalid, 0);
        cyc();

        // Randomized segments
        for (int s = 0; s < 6; s++) begin
            int pc, pv, ps, pb;
            pc = $urandom_range(90, 10); pv = $urandom_range(95, 20);
            ps = $urandom_range(95, 20); pb = $urandom_range(40, 3);
            for (int i = 0; i < 250; i++) begin
                bus.cpu_req = ($urandom_range(99) < pc);
                bus.cpu_we = $urandom_range(1); bus.cpu_addr = AW'($urandom_range(31));
                bus.cpu_wdata = DW'($urandom); bus.cpu_instr_boundary = ($urandom_range(99) < pb);
                bus.vid_req = ($urandom_range(99) < pv); bus.vid_addr = AW'($urandom_range(31));
                bus.ss_req = ($urandom_range(99) < ps); bus.ss_we = $urandom_range(1);
                bus.ss_addr = AW'($urandom_range(31)); bus.ss_wdata = DW'($urandom);
                if ($urandom_range(99) < 5) bus.ss_lock_req = ~bus.ss_lock_req;
                reset_n = ($urandom_range(499) != 0);
                cyc();
            end
        end
        reset_n = 1; idle(); cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port 4-bit CPU data RAM among three requesters: the CPU core, the LCD/video scanout reader, and the savestate engine. The CPU keeps fixed-timing, zero-wait access whenever it is running. Video gets idle slots, with a starvation guarantee while the bus is locked. Savestate gets exclusive access only after it locks the bus, which halts the CPU at an instruction boundary. The block sits between the CPU bus-transfer datapath and the RAM macro.

## Interface
- ADDR_WIDTH, 12, RAM address width (nibble addressed)
- DATA_WIDTH, 4, RAM data width
- STARVE_LIMIT, 8, max consecutive denied video cycles while LOCKED before video is forced a slot (>=1)

- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- cpu_req / cpu_we  in  1  CPU access strobe / write enable, valid per cycle
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_rdata  out  DATA_WIDTH  read data, cycle after CPU read
- cpu_instr_boundary  in  1  high on the DECODE cycle of the CPU sequencer
- cpu_halt  out  1  freezes CPU instruction fetch
- vid_req  in  1  video read request, held until acked
- vid_addr  in  ADDR_WIDTH  video address
- vid_ack  out  1  video granted this cycle
- vid_rdata / vid_rvalid  out  DATA_WIDTH / 1  video read data and its valid
- ss_lock_req  in  1  savestate requests exclusive bus
- ss_locked  out  1  lock held
- ss_req / ss_we  in  1  savestate access request (held until acked) / write enable
- ss_addr / ss_wdata  in  ADDR_WIDTH / DATA_WIDTH  savestate address / write data
- ss_ack  out  1  savestate granted this cycle
- ss_rdata / ss_rvalid  out  DATA_WIDTH / 1  savestate read data and its valid
- ram_addr / ram_we / ram_wdata  out  ADDR_WIDTH / 1 / DATA_WIDTH  to RAM macro
- ram_rdata  in  DATA_WIDTH  RAM read data, 1-cycle synchronous latency

## Operation
- States: SHARED, LOCK_WAIT, LOCKED, UNLOCK. Reset state is SHARED.
- Grant is combinational from the state and the requests. ram_addr, ram_we and ram_wdata mux from the granted requester.
- With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Writes are never issued to RAM for an un-acked requester.
- SHARED:
  - CPU has absolute priority when cpu_req=1.
  - Otherwise video is granted if vid_req=1.
  - ss_req is ignored; ss_ack=0.
- SHARED→LOCK_WAIT: when ss_lock_req=1.
- LOCK_WAIT:
  - Arbitration is the same as SHARED.
  - On a cycle with cpu_instr_boundary=1, cpu_halt sets (registered, high from the next cycle) and the next state is LOCKED.
- LOCKED:
  - ss_locked=1 and cpu_halt=1. cpu_req is ignored (no RAM access).
  - Savestate has priority over video.
  - starve_cnt increments each cycle vid_req=1 and is denied. When it reaches STARVE_LIMIT, video wins the next arbitration over savestate.
  - starve_cnt clears on any vid_ack and on leaving LOCKED. It saturates and never wraps.
- LOCKED→UNLOCK: when ss_lock_req=0. ss_locked drops the same cycle as the transition, i.e. it is low in UNLOCK.
- UNLOCK:
  - No savestate grants; video may be granted.
  - Lasts exactly 1 cycle so an outstanding ss read returns.
  - Then SHARED, with cpu_halt cleared on entry to SHARED.
- ss_lock_req deasserted during LOCK_WAIT returns to SHARED directly; cpu_halt is never asserted.
- Read return:
  - A registered owner tag records who was granted a read.
  - Next cycle: the matching *_rvalid=1 and *_rdata=ram_rdata.
  - cpu_rdata always equals ram_rdata.
  - Writes produce no rvalid.

## Timing
- Reset values: cpu_halt=0, ss_locked=0, vid_ack=0, ss_ack=0, vid_rvalid=0, ss_rvalid=0, starve_cnt=0, owner tag=none, state=SHARED.
- CPU access latency is 0 wait states. Read data arrives 1 cycle after cpu_req.
- vid_ack and ss_ack are asserted in the grant cycle. The requester may change address the following cycle.
- rvalid is exactly 1 cycle after ack, for one cycle per read.
- Lock latency: cycles from ss_lock_req to ss_locked = (cycles to next cpu_instr_boundary) + 1.
- Simultaneous events:
  - cpu_instr_boundary in the same cycle as ss_lock_req rises: the boundary is not consumed; wait for the next one.
  - In LOCKED, ss_lock_req falling in the same cycle as ss_req=1: the ss access is still granted that cycle.
- Reset mid-lock: everything returns to reset values immediately. A pending rvalid is dropped.

## Test plan
- SHARED, cpu_req every other cycle, vid_req held → video acked only on CPU-idle cycles; CPU read of addr 0x0A5 returns the preloaded nibble 0x7 next cycle on cpu_rdata.
- ss_lock_req raised with boundary 5 cycles later → cpu_halt high from cycle 6 and ss_locked high from cycle 6. No CPU RAM write occurs after cpu_halt even if cpu_req/cpu_we=1.
- LOCKED, STARVE_LIMIT=8, ss_req and vid_req held continuously → pattern of 8 ss_ack, 1 vid_ack, repeating. rvalid for each arrives 1 cycle after its ack.
- ss write 0xC to 0x123, then ss read of 0x123 → ss_rvalid with ss_rdata=0xC. Drop ss_lock_req → UNLOCK for 1 cycle, then SHARED with cpu_halt=0.
- ss_lock_req pulsed for 2 cycles with no boundary → return to SHARED; cpu_halt and ss_locked never assert.
- reset_n low while LOCKED with a read in flight → next cycle: all outputs at reset values, no rvalid.
